// File: rtl/mtr_drv_pkg.sv
// Shared constants, state type and duty clamp helper for the mtr_drv H-bridge PWM driver.
package mtr_drv_pkg;

  localparam int unsigned FRAME_W = 12;
  localparam logic [FRAME_W-1:0] FRAME_LAST = 12'hFFF;

  localparam int unsigned DEAD_CYC_DEF = 64;
  localparam logic [FRAME_W-1:0] MAX_DUTY_DEF = 12'hF80;

  typedef enum logic [1:0] {
    DEAD,
    FWD,
    REV
  } drv_state_t;

  function automatic logic [FRAME_W-1:0] clamp_duty(input logic [FRAME_W-1:0] duty,
                                                    input logic [FRAME_W-1:0] ceil);
    return (duty > ceil) ? ceil : duty;
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_cmp.sv
// 12-bit PWM frame counter with synchronous clear; emits next-cycle pwm level and frame start.
module pwm_cmp
  import mtr_drv_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [FRAME_W-1:0] duty_i,
  output logic               frame_last_o,
  output logic               pwm_o,
  output logic               frm_strt_o
);

  logic [FRAME_W-1:0] pos_q, pos_d;

  // Free-running counter wraps 4095 -> 0 on its own; clear only restarts a frame
  assign pos_d = clr_i ? '0 : pos_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign frame_last_o = (pos_q == FRAME_LAST);
  // Levels describe the position being loaded, so the parent can register them directly
  assign pwm_o        = (pos_d < duty_i);
  assign frm_strt_o   = (pos_d == '0);

endmodule

// File: rtl/mtr_drv.sv
// Signed-magnitude motor command to dual gate-drive PWM with break-before-make dead time.
// Define DUTY_CLAMP_EN to clamp sampled duty to MAX_DUTY (guaranteed bootstrap refresh).
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int unsigned        DEAD_CYC = DEAD_CYC_DEF,
  parameter logic [FRAME_W-1:0] MAX_DUTY = MAX_DUTY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] mtr_duty,
  input  logic               rev,
  output logic               PWM_fwd,
  output logic               PWM_rev,
  output logic               frm_strt,
  output logic               dead
);

  if (DEAD_CYC < 1 || DEAD_CYC > 4095 || MAX_DUTY == '0) begin : g_bad_param
    $error("mtr_drv: DEAD_CYC must be 1..4095 and MAX_DUTY nonzero");
  end

  localparam logic [FRAME_W-1:0] DeadLast = FRAME_W'(DEAD_CYC - 1);

  drv_state_t         state_q, state_d;
  logic [FRAME_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [FRAME_W-1:0] duty_q, duty_d;
  logic               dir_q, dir_d;
  logic [FRAME_W-1:0] cmd_duty;
  drv_state_t         cmd_state;
  logic               frame_last, pwm_raw, frm_raw;

`ifdef DUTY_CLAMP_EN
  assign cmd_duty = clamp_duty(mtr_duty, MAX_DUTY);
`else
  assign cmd_duty = mtr_duty;
`endif

  assign cmd_state = rev ? REV : FWD;

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    unique case (state_q)
      DEAD: begin
        if (dead_cnt_q == DeadLast) begin
          state_d    = cmd_state;
          duty_d     = cmd_duty;
          dir_d      = rev;
          dead_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      FWD, REV: begin
        if (frame_last) begin
          // Zero-duty reversal needs no dead time: neither bridge leg is driven
          if (rev != dir_q && mtr_duty != '0) begin
            state_d    = DEAD;
            dead_cnt_d = '0;
            duty_d     = '0;
          end else begin
            state_d = cmd_state;
            duty_d  = cmd_duty;
            dir_d   = rev;
          end
        end
      end
      default: begin
        state_d    = DEAD;
        dead_cnt_d = '0;
      end
    endcase
  end

  pwm_cmp u_pwm_cmp (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (state_q == DEAD),
    .duty_i      (duty_d),
    .frame_last_o(frame_last),
    .pwm_o       (pwm_raw),
    .frm_strt_o  (frm_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DEAD;
      dead_cnt_q <= '0;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      PWM_fwd    <= 1'b0;
      PWM_rev    <= 1'b0;
      frm_strt   <= 1'b0;
      dead       <= 1'b1;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      // Gating each leg by its own next state makes both-high unreachable
      PWM_fwd    <= (state_d == FWD) && pwm_raw;
      PWM_rev    <= (state_d == REV) && pwm_raw;
      frm_strt   <= (state_d != DEAD) && frm_raw;
      dead       <= (state_d == DEAD);
    end
  end

endmodule
